hazard_control_unit: RTL and testbench



---
 rtl/hazard_control_unit_if.sv | 39 +++
 rtl/hazard_control_unit.sv | 127 ++++++++++++
 tb/tb_hazard_control_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Signal bundle between the decode-stage pipeline control and the hazard controller.
// The slave side is the controller; the master side is the pipeline that consumes its controls.
interface hazard_control_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              mem_busy;

    logic              pc_we;
    logic              if_id_we;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic              halted;
    logic [CNT_W-1:0]  stall_count;
    logic [1:0]        dbg_state;

    // Controls are pure levels sampled every cycle; there is no valid/ready
    // handshake, id_valid only qualifies the decode-stage hazard terms.
    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
        output pc_we, if_id_we, id_ex_bubble, if_id_flush, halted, stall_count, dbg_state
    );

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_mem_read, ex_branch_taken, mem_busy,
        input  pc_we, if_id_we, id_ex_bubble, if_id_flush, halted, stall_count, dbg_state
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls with configurable bubble count,
// taken-branch flush, memory-busy freeze, sticky halt and a saturating stall counter.
module hazard_control_unit #(
    parameter int         REG_AW       = 5,
    parameter logic [6:0] HALT_OPCODE  = 7'b1111111,
    parameter int         LOAD_BUBBLES = 1,
    parameter int         CNT_W        = 16
) (
    input logic             clk,
    input logic             reset,
    hazard_control_unit_if.slave hz
);
    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_LU_WAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [2:0]       LB_INIT = 3'(LOAD_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        bub_q, bub_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [REG_AW-1:0] ex_rd;
    logic              load_use, halt_req;
    logic              pc_we, if_id_we, id_ex_bubble, if_id_flush;

    assign ex_rd    = hz.ex_rd;
    // x0 is never a real producer, and unread operands cannot create a hazard.
    assign load_use = hz.id_valid & hz.ex_mem_read & (ex_rd != '0) &
                      ((hz.id_uses_rs1 & (ex_rd == hz.id_rs1)) |
                       (hz.id_uses_rs2 & (ex_rd == hz.id_rs2)));
    assign halt_req = hz.id_valid & (hz.id_opcode == HALT_OPCODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            bub_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bub_d        = bub_q;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hz.ex_branch_taken) begin
                    id_ex_bubble = 1'b1;
                    if_id_flush  = 1'b1;
                end else if (hz.mem_busy) begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                end else if (load_use) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = S_LU_WAIT;
                        bub_d   = LB_INIT;
                    end
                end else if (halt_req) begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = S_HALT;
                end
            end
            S_LU_WAIT: begin
                if (hz.ex_branch_taken) begin
                    id_ex_bubble = 1'b1;
                    if_id_flush  = 1'b1;
                    state_d      = S_RUN;
                    bub_d        = 3'd0;
                end else if (hz.mem_busy) begin
                    pc_we    = 1'b0;
                    if_id_we = 1'b0;
                end else begin
                    pc_we        = 1'b0;
                    if_id_we     = 1'b0;
                    id_ex_bubble = 1'b1;
                    bub_d        = bub_q - 3'd1;
                    if (bub_q == 3'd1) state_d = S_RUN;
                end
            end
            S_HALT: begin
                pc_we        = 1'b0;
                if_id_we     = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
                state_d = S_RUN;
                bub_d   = 3'd0;
            end
        endcase
        // Reset holds the pipeline stalled with a bubble until it is released.
        if (reset) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!pc_we && (state_q != S_HALT) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign hz.pc_we        = pc_we;
    assign hz.if_id_we     = if_id_we;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.halted       = (state_q == S_HALT);
    assign hz.stall_count  = cnt_q;
    assign hz.dbg_state    = state_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1 bubble / 16-bit counter and
// 3 bubbles / 4-bit counter) share stimulus and are scored against a cycle model.
module tb_hazard_control_unit;
  localparam int LB_A = 1;
  localparam int CW_A = 16;
  localparam int LB_B = 3;
  localparam int CW_B = 4;
  localparam logic [6:0] OP_HALT = 7'h7F;
  localparam logic [6:0] OP_ADD  = 7'h33;
  localparam logic [3:0] O_PASS   = 4'b1100;
  localparam logic [3:0] O_STALL  = 4'b0010;
  localparam logic [3:0] O_FREEZE = 4'b0000;
  localparam logic [3:0] O_FLUSH  = 4'b1111;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.REG_AW(5), .CNT_W(CW_A)) if_a ();
  hazard_control_unit_if #(.REG_AW(5), .CNT_W(CW_B)) if_b ();

  hazard_control_unit #(.REG_AW(5), .HALT_OPCODE(OP_HALT), .LOAD_BUBBLES(LB_A), .CNT_W(CW_A)) u_a (
    .clk(clk), .reset(reset), .hz(if_a)
  );
  hazard_control_unit #(.REG_AW(5), .HALT_OPCODE(OP_HALT), .LOAD_BUBBLES(LB_B), .CNT_W(CW_B)) u_b (
    .clk(clk), .reset(reset), .hz(if_b)
  );

  logic [20:0] act_a, act_b;
  assign act_a = {if_a.pc_we, if_a.if_id_we, if_a.id_ex_bubble, if_a.if_id_flush, if_a.halted, if_a.stall_count};
  assign act_b = {if_b.pc_we, if_b.if_id_we, if_b.id_ex_bubble, if_b.if_id_flush, if_b.halted, 12'd0, if_b.stall_count};

  // scoreboard
  logic [20:0] exp_a_q[$];
  logic [20:0] exp_b_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    logic [20:0] e;
    if (exp_a_q.size() > 0) begin
      e = exp_a_q.pop_front();
      chk("dut_a_cycle", {11'd0, act_a}, {11'd0, e});
    end
    if (exp_b_q.size() > 0) begin
      e = exp_b_q.pop_front();
      chk("dut_b_cycle", {11'd0, act_b}, {11'd0, e});
    end
  end

  // reference model: bubbles still owed after the first, a sticky halt flag, a clamped count
  int lb[2]   = '{LB_A, LB_B};
  int cmax[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  int m_owe[2], m_halt[2], m_cnt[2];
  int n_owe[2] = '{0, 0};
  int n_halt[2] = '{0, 0};
  int n_cnt[2] = '{0, 0};

  // driver
  task automatic drive(input bit r, input bit idv, input logic [6:0] opc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                       input logic [4:0] rd, input bit mr, input bit br, input bit mb);
    bit lu, hr;
    logic [3:0] o;
    logic [20:0] e;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_owe[k] = n_owe[k]; m_halt[k] = n_halt[k]; m_cnt[k] = n_cnt[k];
    end
    #1;
    reset = r;
    if_a.id_valid = idv;  if_b.id_valid = idv;
    if_a.id_opcode = opc; if_b.id_opcode = opc;
    if_a.id_rs1 = rs1;    if_b.id_rs1 = rs1;
    if_a.id_rs2 = rs2;    if_b.id_rs2 = rs2;
    if_a.id_uses_rs1 = u1; if_b.id_uses_rs1 = u1;
    if_a.id_uses_rs2 = u2; if_b.id_uses_rs2 = u2;
    if_a.ex_rd = rd;      if_b.ex_rd = rd;
    if_a.ex_mem_read = mr; if_b.ex_mem_read = mr;
    if_a.ex_branch_taken = br; if_b.ex_branch_taken = br;
    if_a.mem_busy = mb;   if_b.mem_busy = mb;
    lu = idv && mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    hr = idv && (opc == OP_HALT);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_owe[k] = 0; m_halt[k] = 0; m_cnt[k] = 0;
      end
      n_owe[k] = m_owe[k]; n_halt[k] = m_halt[k]; n_cnt[k] = m_cnt[k];
      if (r) o = O_STALL;
      else if (m_halt[k] != 0) o = O_STALL;
      else if (br) begin o = O_FLUSH; n_owe[k] = 0; end
      else if (mb) o = O_FREEZE;
      else if (m_owe[k] > 0) begin o = O_STALL; n_owe[k] = m_owe[k] - 1; end
      else if (lu) begin o = O_STALL; n_owe[k] = lb[k] - 1; end
      else if (hr) begin o = O_STALL; n_halt[k] = 1; end
      else o = O_PASS;
      if (r) begin
        n_owe[k] = 0; n_halt[k] = 0; n_cnt[k] = 0;
      end else if (!o[3] && m_halt[k] == 0 && m_cnt[k] < cmax[k]) begin
        n_cnt[k] = m_cnt[k] + 1;
      end
      e = {o, m_halt[k][0], 16'(m_cnt[k])};
      if (k == 0) exp_a_q.push_back(e);
      else exp_b_q.push_back(e);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_reset();
    drive(1, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_reset();
    settle();
    chk("reset_pc_we", {31'd0, if_a.pc_we}, 32'd0);
    chk("reset_bubble", {31'd0, if_b.id_ex_bubble}, 32'd1);
    chk("reset_halted", {31'd0, if_b.halted}, 32'd0);
    idle_reset();

    // lw x5 in EX, add x6,x5,x1 in ID; B sees a freeze on its second bubble
    drive(0, 1, OP_ADD, 5, 1, 1, 1, 5, 1, 0, 0);
    settle();
    chk("lu1_a_stall", {28'd0, act_a[20:17]}, {28'd0, O_STALL});
    drive(0, 1, OP_ADD, 5, 1, 1, 1, 0, 0, 0, 1);
    settle();
    chk("lu1_a_count", 32'(if_a.stall_count), 32'd1);
    chk("lu3_b_freeze_no_bubble", {31'd0, if_b.id_ex_bubble}, 32'd0);
    drive(0, 1, OP_ADD, 5, 1, 1, 1, 0, 0, 0, 0);
    settle();
    chk("lu1_a_pass_after", {28'd0, act_a[20:17]}, {28'd0, O_PASS});
    drive(0, 1, OP_ADD, 5, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 1, OP_ADD, 5, 1, 1, 1, 0, 0, 0, 0);
    settle();
    chk("lu3_b_count", 32'(if_b.stall_count), 32'd4);
    chk("lu3_b_pass_after", {28'd0, act_b[20:17]}, {28'd0, O_PASS});
    idle_reset();

    // x0 destination and an unread rs2 never stall
    drive(0, 1, OP_ADD, 0, 3, 1, 1, 0, 1, 0, 0);
    settle();
    chk("x0_no_stall", {31'd0, if_b.pc_we}, 32'd1);
    drive(0, 1, OP_ADD, 2, 7, 1, 0, 7, 1, 0, 0);
    settle();
    chk("unused_rs2_no_stall", {31'd0, if_a.pc_we}, 32'd1);

    // taken branch beats a load-use hazard
    drive(0, 1, OP_ADD, 5, 1, 1, 1, 5, 1, 1, 0);
    settle();
    chk("branch_flush", {28'd0, act_b[20:17]}, {28'd0, O_FLUSH});
    drive(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("branch_no_lu_wait", {28'd0, act_b[20:17]}, {28'd0, O_PASS});

    // halt: sticky through branch and mem_busy until reset
    idle_reset();
    drive(0, 1, OP_HALT, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("halt_req_stall", {28'd0, act_a[20:17]}, {28'd0, O_STALL});
    for (int i = 0; i < 4; i++) drive(0, 1, OP_ADD, 0, 0, 0, 0, 0, 0, i[0], i[1]);
    settle();
    chk("halt_sticky", {31'd0, if_a.halted}, 32'd1);
    chk("halt_count_frozen", 32'(if_b.stall_count), 32'd1);
    idle_reset();
    settle();
    chk("halt_cleared", {31'd0, if_b.halted}, 32'd0);
    chk("halt_count_cleared", 32'(if_a.stall_count), 32'd0);

    // 2^4+5 freeze cycles saturate the 4-bit counter
    for (int i = 0; i < 21; i++) drive(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("sat_b_count", 32'(if_b.stall_count), 32'd15);
    chk("sat_a_count", 32'(if_a.stall_count), 32'd21);

    // randomized traffic with small register ranges so hazards are frequent
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0) ? OP_HALT : OP_ADD,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end
    settle();
    chk("queues_drained", 32'(exp_a_q.size() + exp_b_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
